// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encodings and widths for the SRAM controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int HALF_W  = 16;
  localparam int SRAM_AW = 18;
  localparam int CNT_W   = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - wait-state counter with clear, enable and terminal count
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int TERMINAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count;

  // Count wait cycles; clear has priority so every state change restarts at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == TC);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit pipeline port onto a 16-bit async SRAM; optional range check via SRAM_CTRL_ADDR_CHECK_EN
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_WORDS    = 131072
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               addr_err,
  inout  wire  [HALF_W-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
  localparam logic [31:0] WORDS_W = 32'(SRAM_WORDS);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t            state;
  state_t            next_state;
  logic              req;
  logic              is_write;
  logic              err_q;
  logic              cnt_done;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              out_of_range;
  logic [31:0]       offset;
  logic [31:0]       word_idx;
  logic              dq_drive;
  logic [HALF_W-1:0] dq_out;

  assign req      = wr_en | rd_en;
  assign offset   = address - BASE_W;
  assign word_idx = offset >> 2;

  // Below-base addresses wrap the offset, so they need their own compare
  assign out_of_range = CHECK_EN & ((address < BASE_W) | (word_idx >= WORDS_W));

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_DQ   = dq_drive ? dq_out : 'z;
  assign addr_err  = CHECK_EN & (state == ST_DONE) & err_q;

  assign cnt_clear  = (next_state != state);
  assign cnt_enable = (state == ST_LOW) | (state == ST_HIGH);

  sram_wait_counter #(
    .TERMINAL (ACCESS_CYCLES - 1)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .done   (cnt_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus SRAM strobes, address and write data for the current half
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    SRAM_ADDR  = '0;
    SRAM_WE_N  = 1'b1;
    dq_drive   = 1'b0;
    dq_out     = '0;
    case (state)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          next_state = out_of_range ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        SRAM_ADDR = {word_idx[SRAM_AW-2:0], 1'b0};
        SRAM_WE_N = ~is_write;
        dq_drive  = is_write;
        dq_out    = write_data[HALF_W-1:0];
        if (cnt_done) begin
          next_state = ST_HIGH;
        end
      end
      ST_HIGH: begin
        SRAM_ADDR = {word_idx[SRAM_AW-2:0], 1'b1};
        SRAM_WE_N = ~is_write;
        dq_drive  = is_write;
        dq_out    = write_data[31:HALF_W];
        if (cnt_done) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        ready      = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Latch operation type and range error when leaving IDLE; write wins a tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      is_write <= wr_en;
      err_q    <= out_of_range;
    end
  end

  // Capture each read half on the last wait cycle of its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!is_write && cnt_done) begin
      if (state == ST_LOW) begin
        read_data[HALF_W-1:0] <= SRAM_DQ;
      end else if (state == ST_HIGH) begin
        read_data[31:HALF_W] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller (two instances: ACCESS_CYCLES 2 and 1)
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Instance 1: default parameters
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, addr_err;
  wire  [15:0] dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;
  int          mode1;
  logic [15:0] mem1 [0:262143];

  // Instance 2: ACCESS_CYCLES = 1
  logic        wr_en2, rd_en2;
  logic [31:0] address2, write_data2, read_data2;
  logic        ready2, addr_err2;
  wire  [15:0] dq2;
  logic [17:0] sram_addr2;
  logic        ub_n2, lb_n2, ce_n2, oe_n2, we_n2;
  logic [15:0] mem2 [0:262143];

  always #5 clk = ~clk;

  sram_controller u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .addr_err(addr_err),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
  );

  sram_controller #(.ACCESS_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .rd_en(rd_en2), .address(address2),
    .write_data(write_data2), .read_data(read_data2), .ready(ready2), .addr_err(addr_err2),
    .SRAM_DQ(dq2), .SRAM_ADDR(sram_addr2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2),
    .SRAM_CE_N(ce_n2), .SRAM_OE_N(oe_n2), .SRAM_WE_N(we_n2)
  );

  // SRAM models: drive only while WE_N is high; mode1 2 drives a probe pattern 5A5A
  assign dq  = (we_n && !oe_n && mode1 != 0) ? ((mode1 == 2) ? 16'h5A5A : mem1[sram_addr]) : 16'hzzzz;
  assign dq2 = (we_n2 && !oe_n2) ? mem2[sram_addr2] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n) mem1[sram_addr] <= dq;
    if (!we_n2) mem2[sram_addr2] <= dq2;
  end

  task automatic test_reset();
    rst = 1'b0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr_en2 = 0; rd_en2 = 0; address2 = 0; write_data2 = 0; mode1 = 2;
    repeat (2) @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", ready); else pass_cnt++;
    total_cnt++; if (we_n !== 1'b1) $display("FAIL rst_we_n: got %b exp 1", we_n); else pass_cnt++;
    total_cnt++; if (dq !== 16'h5A5A) $display("FAIL rst_dq_released: got %h exp 5a5a", dq); else pass_cnt++;
    total_cnt++; if (read_data !== 32'h0) $display("FAIL rst_read_data: got %h exp 0", read_data); else pass_cnt++;
    total_cnt++; if (addr_err !== 1'b0) $display("FAIL rst_addr_err: got %b exp 0", addr_err); else pass_cnt++;
    total_cnt++; if (sram_addr !== 18'h0) $display("FAIL rst_sram_addr: got %h exp 0", sram_addr); else pass_cnt++;
    total_cnt++; if ({ub_n, lb_n, ce_n, oe_n} !== 4'b0) $display("FAIL rst_ties: got %b exp 0000", {ub_n, lb_n, ce_n, oe_n}); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [17:0] ea;
    logic [15:0] ed;
    logic        ew, er;
    mode1 = 2;
    wr_en = 1; address = 32'd1024; write_data = 32'hDEADBEEF;
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL wr_ready_c0: got %b exp 0", ready); else pass_cnt++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 2) begin ea = 18'd0; ed = 16'hBEEF; ew = 0; er = 0; end
      else if (c <= 4) begin ea = 18'd1; ed = 16'hDEAD; ew = 0; er = 0; end
      else begin ea = 18'd0; ed = 16'h5A5A; ew = 1; er = 1; end
      total_cnt++; if (sram_addr !== ea) $display("FAIL wr_addr_c%0d: got %h exp %h", c, sram_addr, ea); else pass_cnt++;
      total_cnt++; if (dq !== ed) $display("FAIL wr_dq_c%0d: got %h exp %h", c, dq, ed); else pass_cnt++;
      total_cnt++; if (we_n !== ew) $display("FAIL wr_we_n_c%0d: got %b exp %b", c, we_n, ew); else pass_cnt++;
      total_cnt++; if (ready !== er) $display("FAIL wr_ready_c%0d: got %b exp %b", c, ready, er); else pass_cnt++;
    end
    wr_en = 0;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL wr_idle_ready: got %b exp 1", ready); else pass_cnt++;
  endtask

  task automatic test_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    mode1 = 1;
    rd_en = 1; address = addr;
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL %s_ready_c0: got %b exp 0", tag, ready); else pass_cnt++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total_cnt++; if (we_n !== 1'b1) $display("FAIL %s_we_n_c%0d: got %b exp 1", tag, c, we_n); else pass_cnt++;
      total_cnt++; if (ready !== (c == 5)) $display("FAIL %s_ready_c%0d: got %b exp %b", tag, c, ready, (c == 5)); else pass_cnt++;
    end
    total_cnt++; if (read_data !== exp) $display("FAIL %s_data: got %h exp %h", tag, read_data, exp); else pass_cnt++;
    rd_en = 0;
    @(negedge clk);
  endtask

  task automatic test_write_priority();
    mode1 = 2;
    wr_en = 1; rd_en = 1; address = 32'd1028; write_data = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total_cnt++; if (sram_addr !== 18'd2) $display("FAIL both_addr_low: got %h exp 2", sram_addr); else pass_cnt++;
        total_cnt++; if (we_n !== 1'b0) $display("FAIL both_we_n: got %b exp 0", we_n); else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt++; if (sram_addr !== 18'd3) $display("FAIL both_addr_high: got %h exp 3", sram_addr); else pass_cnt++;
        total_cnt++; if (dq !== 16'h1234) $display("FAIL both_dq_high: got %h exp 1234", dq); else pass_cnt++;
      end
    end
    total_cnt++; if (ready !== 1'b1) $display("FAIL both_ready: got %b exp 1", ready); else pass_cnt++;
    total_cnt++; if (read_data !== 32'hDEADBEEF) $display("FAIL both_read_data: got %h exp deadbeef", read_data); else pass_cnt++;
    wr_en = 0; rd_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mode1 = 2;
    wr_en = 1; address = 32'd1024; write_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    total_cnt++; if (we_n !== 1'b0) $display("FAIL mid_we_n_before: got %b exp 0", we_n); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (we_n !== 1'b1) $display("FAIL mid_we_n_reset: got %b exp 1", we_n); else pass_cnt++;
    total_cnt++; if (dq !== 16'h5A5A) $display("FAIL mid_dq_reset: got %h exp 5a5a", dq); else pass_cnt++;
    total_cnt++; if (sram_addr !== 18'd0) $display("FAIL mid_addr_reset: got %h exp 0", sram_addr); else pass_cnt++;
    total_cnt++; if (read_data !== 32'h0) $display("FAIL mid_read_data: got %h exp 0", read_data); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL mid_ready_reset: got %b exp 0", ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total_cnt++; if (we_n !== 1'b0) $display("FAIL mid_restart_we_n: got %b exp 0", we_n); else pass_cnt++;
        total_cnt++; if (dq !== 16'hF00D) $display("FAIL mid_restart_dq: got %h exp f00d", dq); else pass_cnt++;
      end
      total_cnt++; if (ready !== (c == 5)) $display("FAIL mid_ready_c%0d: got %b exp %b", c, ready, (c == 5)); else pass_cnt++;
    end
    wr_en = 0;
    @(negedge clk);
  endtask

  task automatic test_range();
    mode1 = 1;
    rd_en = 1; address = 32'd1024 + 32'd4 * 32'd131072;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL range_ready_c1: got %b exp 1", ready); else pass_cnt++;
    total_cnt++; if (addr_err !== 1'b1) $display("FAIL range_addr_err: got %b exp 1", addr_err); else pass_cnt++;
    total_cnt++; if (we_n !== 1'b1) $display("FAIL range_we_n: got %b exp 1", we_n); else pass_cnt++;
    total_cnt++; if (read_data !== 32'h0) $display("FAIL range_read_data: got %h exp 0", read_data); else pass_cnt++;
    rd_en = 0;
    @(negedge clk);
    total_cnt++; if (addr_err !== 1'b0) $display("FAIL range_addr_err_idle: got %b exp 0", addr_err); else pass_cnt++;
`else
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total_cnt++; if (addr_err !== 1'b0) $display("FAIL range_addr_err_c%0d: got %b exp 0", c, addr_err); else pass_cnt++;
      total_cnt++; if (ready !== (c == 5)) $display("FAIL range_ready_c%0d: got %b exp %b", c, ready, (c == 5)); else pass_cnt++;
    end
    total_cnt++; if (read_data !== 32'hCAFEF00D) $display("FAIL range_read_data: got %h exp cafef00d", read_data); else pass_cnt++;
    rd_en = 0;
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      wr_en2 = 1; address2 = 32'd1024 + 32'(4 * k);
      write_data2 = (k == 0) ? 32'h11112222 : 32'h33334444;
      repeat (3) @(negedge clk);
      total_cnt++; if (ready2 !== 1'b1) $display("FAIL ac1_wr%0d_ready: got %b exp 1", k, ready2); else pass_cnt++;
      wr_en2 = 0;
      @(negedge clk);
    end
    rd_en2 = 1; address2 = 32'd1024;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total_cnt++; if (ready2 !== (c == 3 || c == 7)) $display("FAIL ac1_ready_c%0d: got %b exp %b", c, ready2, (c == 3 || c == 7)); else pass_cnt++;
      if (c == 3) begin
        total_cnt++; if (read_data2 !== 32'h11112222) $display("FAIL ac1_rd0: got %h exp 11112222", read_data2); else pass_cnt++;
        address2 = 32'd1028;
      end
    end
    total_cnt++; if (read_data2 !== 32'h33334444) $display("FAIL ac1_rd1: got %h exp 33334444", read_data2); else pass_cnt++;
    rd_en2 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(32'd1024, 32'hDEADBEEF, "rd1024");
    test_write_priority();
    test_read(32'd1028, 32'h12345678, "rd1028");
    test_reset_mid();
    test_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
